// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station.
// ALU_RS_OLDEST_FIRST_EN adds a wrap-aware age stamp to each entry.
package rv32im_types;

  function automatic int tag_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  localparam int RS_ROB_DEPTH = 4;
  localparam int RS_DEPTH_DEF = 4;
  localparam int RS_TAG_W     = tag_w(RS_ROB_DEPTH);
  localparam int RS_AGE_W     = $clog2(RS_DEPTH_DEF) + 1;

  typedef struct packed {
    logic                valid;
    logic [31:0]         instr;
    logic                rs1_rdy;
    logic [31:0]         rs1_v;
    logic [RS_TAG_W-1:0] rs1_tag;
    logic                rs2_rdy;
    logic [31:0]         rs2_v;
    logic [RS_TAG_W-1:0] rs2_tag;
    logic [RS_TAG_W-1:0] rob_tag;
`ifdef ALU_RS_OLDEST_FIRST_EN
    logic [RS_AGE_W-1:0] age;
`endif
  } alu_rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_select.sv
// One-hot picker: lowest set index, or oldest wrap-aware age stamp when OLDEST=1.
module rs_select #(
  parameter int N      = 4,
  parameter int AGE_W  = 1,
  parameter bit OLDEST = 1'b0
) (
  input  logic [N-1:0]            cand,
  input  logic [N-1:0][AGE_W-1:0] age,
  output logic [N-1:0]            grant,
  output logic                    found
);

  assign found = |cand;

  generate
    if (OLDEST) begin : g_oldest
      // a is older than b when (b - a) is nonzero with a clear MSB
      function automatic logic is_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] d;
        d = b - a;
        return !d[AGE_W-1] && (d != '0);
      endfunction

      always_comb begin
        grant = cand;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (i != j && cand[j] && is_older(age[j], age[i]))
              grant[i] = 1'b0;
      end
    end else begin : g_lowest
      logic unused_age;
      assign unused_age = ^age;
      assign grant = cand & (~cand + N'(1));
    end
  endgenerate

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: dispatch, CDB wakeup, single registered issue per cycle.
// Define ALU_RS_OLDEST_FIRST_EN for oldest-first select instead of lowest index.
module alu_reservation_station
  import rv32im_types::*;
#(
  parameter int ROB_DEPTH = 4,
  parameter int RS_DEPTH  = 4,
  localparam int TAG_W    = tag_w(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  logic [31:0]      dispatch_instr,
  input  logic             dispatch_rs1_rdy,
  input  logic [31:0]      dispatch_rs1_v,
  input  logic [TAG_W-1:0] dispatch_rs1_tag,
  input  logic             dispatch_rs2_rdy,
  input  logic [31:0]      dispatch_rs2_v,
  input  logic [TAG_W-1:0] dispatch_rs2_tag,
  input  logic [TAG_W-1:0] dispatch_rob_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_result,
  output logic             alu_en,
  output logic [31:0]      alu_instr_out,
  output logic [31:0]      rs1_v,
  output logic [31:0]      rs2_v,
  output logic [TAG_W-1:0] rob_tag
);

  alu_rs_entry_t       ents [RS_DEPTH];
  alu_rs_entry_t       new_ent;
  logic [RS_DEPTH-1:0] free_vec, cand_vec, alloc_oh, issue_oh;
  logic                any_free, issue_found, dispatch_fire;
  logic [31:0]         iss_instr, iss_rs1, iss_rs2;
  logic [TAG_W-1:0]    iss_tag;

  always_comb begin
    free_vec = '0;
    cand_vec = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      free_vec[i] = ~ents[i].valid;
      cand_vec[i] = ents[i].valid & ents[i].rs1_rdy & ents[i].rs2_rdy;
    end
  end

  rs_select #(.N(RS_DEPTH), .AGE_W(1), .OLDEST(1'b0)) u_free_sel (
    .cand  (free_vec),
    .age   ('0),
    .grant (alloc_oh),
    .found (any_free)
  );

`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [RS_AGE_W-1:0]                age_cnt;
  logic [RS_DEPTH-1:0][RS_AGE_W-1:0] age_vec;

  always_comb begin
    age_vec = '0;
    for (int i = 0; i < RS_DEPTH; i++) age_vec[i] = ents[i].age;
  end

  rs_select #(.N(RS_DEPTH), .AGE_W(RS_AGE_W), .OLDEST(1'b1)) u_issue_sel (
    .cand  (cand_vec),
    .age   (age_vec),
    .grant (issue_oh),
    .found (issue_found)
  );
`else
  rs_select #(.N(RS_DEPTH), .AGE_W(1), .OLDEST(1'b0)) u_issue_sel (
    .cand  (cand_vec),
    .age   ('0),
    .grant (issue_oh),
    .found (issue_found)
  );
`endif

  assign dispatch_ready = any_free;
  assign dispatch_fire  = dispatch_valid & any_free;

  // Same-cycle CDB match is captured on dispatch so no wakeup is lost
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.instr   = dispatch_instr;
    new_ent.rs1_rdy = dispatch_rs1_rdy | (cdb_valid && cdb_tag == dispatch_rs1_tag);
    new_ent.rs1_v   = dispatch_rs1_rdy ? dispatch_rs1_v : cdb_result;
    new_ent.rs1_tag = dispatch_rs1_tag;
    new_ent.rs2_rdy = dispatch_rs2_rdy | (cdb_valid && cdb_tag == dispatch_rs2_tag);
    new_ent.rs2_v   = dispatch_rs2_rdy ? dispatch_rs2_v : cdb_result;
    new_ent.rs2_tag = dispatch_rs2_tag;
    new_ent.rob_tag = dispatch_rob_tag;
`ifdef ALU_RS_OLDEST_FIRST_EN
    new_ent.age     = age_cnt;
`endif
  end

  always_comb begin
    iss_instr = '0;
    iss_rs1   = '0;
    iss_rs2   = '0;
    iss_tag   = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (issue_oh[i]) begin
        iss_instr = ents[i].instr;
        iss_rs1   = ents[i].rs1_v;
        iss_rs2   = ents[i].rs2_v;
        iss_tag   = ents[i].rob_tag;
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) ents[i] <= '0;
      alu_en        <= 1'b0;
      alu_instr_out <= '0;
      rs1_v         <= '0;
      rs2_v         <= '0;
      rob_tag       <= '0;
`ifdef ALU_RS_OLDEST_FIRST_EN
      age_cnt       <= '0;
`endif
    end else if (flush) begin
      for (int i = 0; i < RS_DEPTH; i++) ents[i].valid <= 1'b0;
      alu_en <= 1'b0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (ents[i].valid && !ents[i].rs1_rdy && cdb_valid && cdb_tag == ents[i].rs1_tag) begin
          ents[i].rs1_rdy <= 1'b1;
          ents[i].rs1_v   <= cdb_result;
        end
        if (ents[i].valid && !ents[i].rs2_rdy && cdb_valid && cdb_tag == ents[i].rs2_tag) begin
          ents[i].rs2_rdy <= 1'b1;
          ents[i].rs2_v   <= cdb_result;
        end
        if (issue_oh[i]) ents[i].valid <= 1'b0;
        // alloc_oh only targets pre-edge free slots, never the issuing one
        if (dispatch_fire && alloc_oh[i]) ents[i] <= new_ent;
      end
      alu_en <= issue_found;
      if (issue_found) begin
        alu_instr_out <= iss_instr;
        rs1_v         <= iss_rs1;
        rs2_v         <= iss_rs2;
        rob_tag       <= iss_tag;
      end
`ifdef ALU_RS_OLDEST_FIRST_EN
      if (dispatch_fire) age_cnt <= age_cnt + RS_AGE_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station; honours ALU_RS_OLDEST_FIRST_EN for select order.
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        dispatch_valid, dispatch_ready;
  logic [31:0] dispatch_instr;
  logic        dispatch_rs1_rdy, dispatch_rs2_rdy;
  logic [31:0] dispatch_rs1_v, dispatch_rs2_v;
  logic [1:0]  dispatch_rs1_tag, dispatch_rs2_tag, dispatch_rob_tag;
  logic        cdb_valid;
  logic [1:0]  cdb_tag;
  logic [31:0] cdb_result;
  logic        alu_en;
  logic [31:0] alu_instr_out, rs1_v, rs2_v;
  logic [1:0]  rob_tag;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_reservation_station #(.ROB_DEPTH(4), .RS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_instr(dispatch_instr),
    .dispatch_rs1_rdy(dispatch_rs1_rdy), .dispatch_rs1_v(dispatch_rs1_v), .dispatch_rs1_tag(dispatch_rs1_tag),
    .dispatch_rs2_rdy(dispatch_rs2_rdy), .dispatch_rs2_v(dispatch_rs2_v), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rob_tag(dispatch_rob_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_result(cdb_result),
    .alu_en(alu_en), .alu_instr_out(alu_instr_out), .rs1_v(rs1_v), .rs2_v(rs2_v), .rob_tag(rob_tag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; dispatch_valid = 0; dispatch_instr = 0;
    dispatch_rs1_rdy = 0; dispatch_rs1_v = 0; dispatch_rs1_tag = 0;
    dispatch_rs2_rdy = 0; dispatch_rs2_v = 0; dispatch_rs2_tag = 0;
    dispatch_rob_tag = 0; cdb_valid = 0; cdb_tag = 0; cdb_result = 0;
  endtask

  task automatic disp(input logic [31:0] instr,
                      input logic r1rdy, input logic [31:0] r1v, input logic [1:0] r1tag,
                      input logic r2rdy, input logic [31:0] r2v, input logic [1:0] r2tag,
                      input logic [1:0] rob);
    dispatch_valid = 1; dispatch_instr = instr;
    dispatch_rs1_rdy = r1rdy; dispatch_rs1_v = r1v; dispatch_rs1_tag = r1tag;
    dispatch_rs2_rdy = r2rdy; dispatch_rs2_v = r2v; dispatch_rs2_tag = r2tag;
    dispatch_rob_tag = rob;
  endtask

  task automatic bcast(input logic [1:0] t, input logic [31:0] v);
    cdb_valid = 1; cdb_tag = t; cdb_result = v;
  endtask

  logic [1:0] first_tag, second_tag;

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    chk("rst_alu_en", 32'(alu_en), 0);
    chk("rst_instr", alu_instr_out, 0);
    chk("rst_rs1", rs1_v, 0);
    chk("rst_rs2", rs2_v, 0);
    chk("rst_rob", 32'(rob_tag), 0);
    chk("rst_ready", 32'(dispatch_ready), 1);

    // fully ready addi: issue two edges after dispatch
    disp(32'h0070_0293, 1, 5, 0, 1, 7, 0, 2);
    step(); idle();
    chk("t1_no_issue_yet", 32'(alu_en), 0);
    step();
    chk("t1_alu_en", 32'(alu_en), 1);
    chk("t1_instr", alu_instr_out, 32'h0070_0293);
    chk("t1_rs1", rs1_v, 5);
    chk("t1_rs2", rs2_v, 7);
    chk("t1_rob", 32'(rob_tag), 2);
    step();
    chk("t1_alu_en_drop", 32'(alu_en), 0);

    // rs1 waits on tag 3, woken by CDB later
    disp(32'h0031_00b3, 0, 0, 3, 1, 1, 0, 1);
    step(); idle();
    step();
    chk("t2_wait", 32'(alu_en), 0);
    bcast(3, 32'h10);
    step(); idle();
    chk("t2_wake_edge", 32'(alu_en), 0);
    step();
    chk("t2_alu_en", 32'(alu_en), 1);
    chk("t2_rs1", rs1_v, 32'h10);
    chk("t2_rs2", rs2_v, 1);
    chk("t2_rob", 32'(rob_tag), 1);
    step();

    // dispatch coincident with matching broadcast
    disp(32'h0020_8133, 1, 9, 0, 0, 0, 1, 3);
    bcast(1, 32'hABCD);
    step(); idle();
    step();
    chk("t3_alu_en", 32'(alu_en), 1);
    chk("t3_rs1", rs1_v, 9);
    chk("t3_rs2", rs2_v, 32'hABCD);
    chk("t3_rob", 32'(rob_tag), 3);
    step();

    // fill all entries waiting, entry k waits on tag k
    for (int k = 0; k < 4; k++) begin
      disp(32'h100 + 32'(k), 0, 0, 2'(k), 1, 32'(k), 0, 2'(k));
      step();
    end
    idle();
    chk("t4_full", 32'(dispatch_ready), 0);
    disp(32'hDEAD, 1, 1, 0, 1, 1, 0, 0);
    bcast(2, 32'h22);
    step(); idle();
    chk("t4_wake_edge", 32'(alu_en), 0);
    chk("t4_still_full", 32'(dispatch_ready), 0);
    step();
    chk("t4_alu_en", 32'(alu_en), 1);
    chk("t4_rs1", rs1_v, 32'h22);
    chk("t4_instr", alu_instr_out, 32'h102);
    chk("t4_rob", 32'(rob_tag), 2);
    chk("t4_ready_after", 32'(dispatch_ready), 1);

    // refill slot 2, then flush with a concurrent ready dispatch
    disp(32'h200, 0, 0, 1, 1, 0, 0, 1);
    step(); idle();
    chk("t5_full", 32'(dispatch_ready), 0);
    flush = 1;
    disp(32'h300, 1, 3, 0, 1, 3, 0, 3);
    step(); idle();
    chk("t5_ready", 32'(dispatch_ready), 1);
    chk("t5_alu_en", 32'(alu_en), 0);
    for (int t = 0; t < 4; t++) begin
      bcast(2'(t), 32'h99);
      step();
      chk($sformatf("t5_no_issue_%0d", t), 32'(alu_en), 0);
    end
    idle();
    step();
    chk("t5_no_issue_end", 32'(alu_en), 0);

    // A lands in entry 1, B in entry 0 afterwards; both woken together
    disp(32'h400, 0, 0, 0, 1, 0, 0, 3);
    step();
    disp(32'h401, 0, 0, 1, 1, 0, 0, 1);
    step(); idle();
    bcast(0, 32'h77);
    step(); idle();
    step();
    chk("t6_x_issue", 32'(alu_en), 1);
    chk("t6_x_rob", 32'(rob_tag), 3);
    disp(32'h402, 0, 0, 1, 1, 0, 0, 2);
    step(); idle();
    chk("t6_b_dispatched", 32'(alu_en), 0);
    bcast(1, 32'h55);
    step(); idle();
`ifdef ALU_RS_OLDEST_FIRST_EN
    first_tag = 2'd1; second_tag = 2'd2;
`else
    first_tag = 2'd2; second_tag = 2'd1;
`endif
    step();
    chk("t6_first_en", 32'(alu_en), 1);
    chk("t6_first_rob", 32'(rob_tag), 32'(first_tag));
    chk("t6_first_rs1", rs1_v, 32'h55);
    step();
    chk("t6_second_en", 32'(alu_en), 1);
    chk("t6_second_rob", 32'(rob_tag), 32'(second_tag));
    step();
    chk("t6_done", 32'(alu_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
